// File: rtl/pacman_collision_ctrl_pkg.sv
// pacman_collision_ctrl_pkg: shared state type, default constants and distance helper
package pacman_collision_ctrl_pkg;
  typedef enum logic [1:0] {PLAYING, DYING, RESPAWN, GAME_OVER} collision_state_t;
  localparam int HIT_DIST_DEFAULT = 6;
  localparam int DEATH_FRAMES_DEFAULT = 90;
  localparam int START_LIVES_DEFAULT = 3;
  localparam int GRACE_FRAMES_DEFAULT = 60;
  function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/sprite_overlap.sv
// sprite_overlap: combinational box-overlap test between two sprite positions
module sprite_overlap
  import pacman_collision_ctrl_pkg::*;
#(
  parameter int HIT_DIST = HIT_DIST_DEFAULT
) (
  input  logic [8:0] x_a,
  input  logic [8:0] y_a,
  input  logic [8:0] x_b,
  input  logic [8:0] y_b,
  output logic       overlap
);
  logic [8:0] dx, dy;
  always_comb begin
    dx = abs_diff(x_a, x_b);
    dy = abs_diff(y_a, y_b);
    overlap = (dx < 9'(HIT_DIST)) && (dy < 9'(HIT_DIST));
  end
endmodule

// File: rtl/pacman_collision_ctrl.sv
// pacman_collision_ctrl: life/death/respawn FSM; PACMAN_GRACE_EN adds a post-respawn grace window
module pacman_collision_ctrl
  import pacman_collision_ctrl_pkg::*;
#(
`ifdef PACMAN_GRACE_EN
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEFAULT,
`endif
  parameter int HIT_DIST = HIT_DIST_DEFAULT,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEFAULT,
  parameter int START_LIVES = START_LIVES_DEFAULT
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic [8:0] x_pac,
  input  logic [8:0] y_pac,
  input  logic [8:0] x_ghost,
  input  logic [8:0] y_ghost,
  output logic       freeze,
  output logic       respawn,
  output logic       hit,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       invuln
);
  localparam int FW = $clog2(DEATH_FRAMES + 1);
  collision_state_t state;
  logic [FW-1:0] fcnt;
  logic overlap;
  sprite_overlap #(.HIT_DIST(HIT_DIST)) u_overlap (
    .x_a(x_pac), .y_a(y_pac), .x_b(x_ghost), .y_b(y_ghost), .overlap(overlap)
  );
`ifdef PACMAN_GRACE_EN
  localparam int GW = $clog2(GRACE_FRAMES + 1);
  logic [GW-1:0] grace;
  always_ff @(posedge vga_pix_clk)
    if (rst) grace <= '0;
    else if (state == RESPAWN) grace <= GW'(GRACE_FRAMES);
    else if (state == PLAYING && frame_stb && grace != '0) grace <= grace - 1'b1;
  assign invuln = grace != '0;
`else
  assign invuln = 1'b0;
`endif
  // positions are only trusted on frame_stb, before the movers step on that edge
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state <= PLAYING;
      lives <= 2'(START_LIVES);
      fcnt <= '0;
      freeze <= 1'b0;
      respawn <= 1'b0;
      hit <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit <= 1'b0;
      respawn <= 1'b0;
      case (state)
        PLAYING:
          if (frame_stb && overlap && !invuln) begin
            state <= DYING;
            hit <= 1'b1;
            freeze <= 1'b1;
            lives <= lives - 2'd1;
            fcnt <= '0;
          end
        DYING:
          if (frame_stb) begin
            if (fcnt == FW'(DEATH_FRAMES - 1)) begin
              state <= (lives == 2'd0) ? GAME_OVER : RESPAWN;
              game_over <= lives == 2'd0;
              respawn <= lives != 2'd0;
            end else fcnt <= fcnt + 1'b1;
          end
        RESPAWN: begin
          state <= PLAYING;
          freeze <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pacman_collision_ctrl.sv
// tb_pacman_collision_ctrl: scoreboarded checks of hit, death timer, respawn, game over and reset
module tb_pacman_collision_ctrl;
  logic vga_pix_clk = 1'b0, rst = 1'b0, frame_stb = 1'b0;
  logic [8:0] x_pac = '0, y_pac = '0, x_ghost = '0, y_ghost = '0;
  logic freeze, respawn, hit, game_over, invuln;
  logic [1:0] lives;
  int checks = 0, failures = 0;
`ifdef PACMAN_GRACE_EN
  localparam int GRACE = 60;
`else
  localparam int GRACE = 0;
`endif
  // reference model state: 0 playing, 1 dying, 2 respawn, 3 game over
  int m_st = 0, m_lives = 3, m_cnt = 0, m_grace = 0;
  logic [6:0] sb[$];
  logic [6:0] e;

  pacman_collision_ctrl dut (
    .vga_pix_clk(vga_pix_clk), .rst(rst), .frame_stb(frame_stb),
    .x_pac(x_pac), .y_pac(y_pac), .x_ghost(x_ghost), .y_ghost(y_ghost),
    .freeze(freeze), .respawn(respawn), .hit(hit), .lives(lives),
    .game_over(game_over), .invuln(invuln)
  );

  always #5 vga_pix_clk = ~vga_pix_clk;

  function automatic logic [6:0] obs();
    return {hit, freeze, respawn, lives, game_over, invuln};
  endfunction

  task automatic step(input logic r, input logic f, input int xp, input int yp, input int xg, input int yg);
    logic eh;
    bit ov;
    ov = (xp > xg ? xp - xg : xg - xp) < 6 && (yp > yg ? yp - yg : yg - yp) < 6;
    rst = r; frame_stb = f;
    x_pac = 9'(xp); y_pac = 9'(yp); x_ghost = 9'(xg); y_ghost = 9'(yg);
    eh = 1'b0;
    if (r) begin
      m_st = 0; m_lives = 3; m_cnt = 0; m_grace = 0;
    end else if (m_st == 0) begin
      if (f && ov && m_grace == 0) begin
        m_st = 1; eh = 1'b1; m_lives--; m_cnt = 0;
      end else if (f && m_grace > 0) m_grace--;
    end else if (m_st == 1) begin
      if (f && m_cnt == 89) m_st = (m_lives == 0) ? 3 : 2;
      else if (f) m_cnt++;
    end else if (m_st == 2) begin
      m_st = 0; m_grace = GRACE;
    end
    sb.push_back({eh, m_st != 0, m_st == 2, 2'(m_lives), m_st == 3, m_grace != 0});
    @(posedge vga_pix_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      step(1, 0, 0, 0, 50, 50);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL reset_sb: got %b want %b", obs(), e); end
    end
    checks++;
    if (obs() !== 7'b000_11_0_0) begin failures++; $display("FAIL reset_vals: got %b want 0001100", obs()); end
  endtask

  task automatic test_hit();
    step(0, 1, 120, 112, 120, 112);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL hit_sb: got %b want %b", obs(), e); end
    checks++;
    if ({hit, freeze, lives} !== 4'b1110) begin failures++; $display("FAIL hit_first: got %b want 1110", {hit, freeze, lives}); end
    step(0, 0, 120, 112, 120, 112);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL hit_pulse_sb: got %b want %b", obs(), e); end
    checks++;
    if ({hit, freeze} !== 2'b01) begin failures++; $display("FAIL hit_one_cycle: got %b want 01", {hit, freeze}); end
  endtask

  task automatic test_respawn();
    for (int i = 0; i < 89; i++) begin
      step(0, 1, 10, 10, 12, 10);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL dying_sb[%0d]: got %b want %b", i, obs(), e); end
      step(0, 0, 10, 10, 12, 10);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL dying_gap_sb[%0d]: got %b want %b", i, obs(), e); end
    end
    checks++;
    if ({respawn, freeze} !== 2'b01) begin failures++; $display("FAIL no_respawn_89: got %b want 01", {respawn, freeze}); end
    step(0, 1, 10, 10, 200, 200);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL respawn_sb: got %b want %b", obs(), e); end
    checks++;
    if ({respawn, freeze} !== 2'b11) begin failures++; $display("FAIL respawn_90: got %b want 11", {respawn, freeze}); end
    // frame_stb with overlap during the respawn cycle must be ignored
    step(0, 1, 30, 30, 30, 30);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL after_respawn_sb: got %b want %b", obs(), e); end
    checks++;
    if ({hit, respawn, freeze} !== 3'b000) begin failures++; $display("FAIL after_respawn: got %b want 000", {hit, respawn, freeze}); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < GRACE; i++) begin
      step(0, 1, 100, 100, 200, 200);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL grace_drain_sb[%0d]: got %b want %b", i, obs(), e); end
    end
    step(0, 1, 100, 100, 106, 100);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL dx6_sb: got %b want %b", obs(), e); end
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL dx6_nohit: got %b want 0", hit); end
    step(0, 1, 100, 100, 105, 100);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL dx5_sb: got %b want %b", obs(), e); end
    checks++;
    if ({hit, lives} !== 3'b101) begin failures++; $display("FAIL dx5_hit: got %b want 101", {hit, lives}); end
  endtask

  task automatic test_grace();
`ifdef PACMAN_GRACE_EN
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 50, 50, 52, 53);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL grace_sb[%0d]: got %b want %b", i, obs(), e); end
      checks++;
      if ({hit, invuln} !== {1'b0, i < 59}) begin failures++; $display("FAIL grace_window[%0d]: got %b want %b", i, {hit, invuln}, {1'b0, i < 59}); end
    end
`endif
    step(0, 1, 50, 50, 52, 53);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL grace_hit_sb: got %b want %b", obs(), e); end
    checks++;
    if ({hit, lives, invuln} !== 4'b1000) begin failures++; $display("FAIL grace_hit: got %b want 1000", {hit, lives, invuln}); end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 90; i++) begin
      step(0, 1, 10, 10, 12, 10);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL go_dying_sb[%0d]: got %b want %b", i, obs(), e); end
    end
    checks++;
    if ({game_over, freeze, respawn, lives} !== 5'b11000) begin failures++; $display("FAIL game_over: got %b want 11000", {game_over, freeze, respawn, lives}); end
    repeat (5) begin
      step(0, 1, 40, 40, 40, 40);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL go_hold_sb: got %b want %b", obs(), e); end
    end
    checks++;
    if ({hit, game_over} !== 2'b01) begin failures++; $display("FAIL go_nohit: got %b want 01", {hit, game_over}); end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 40, 40, 40, 40);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rst_go_sb: got %b want %b", obs(), e); end
    checks++;
    if (obs() !== 7'b000_11_0_0) begin failures++; $display("FAIL rst_go: got %b want 0001100", obs()); end
    step(0, 1, 40, 40, 40, 40);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rst_rehit_sb: got %b want %b", obs(), e); end
    repeat (10) begin
      step(0, 1, 40, 40, 40, 40);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL rst_dying_sb: got %b want %b", obs(), e); end
    end
    step(1, 1, 40, 40, 40, 40);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rst_dying_sb2: got %b want %b", obs(), e); end
    checks++;
    if (obs() !== 7'b000_11_0_0) begin failures++; $display("FAIL rst_dying: got %b want 0001100", obs()); end
  endtask

  task automatic test_no_stb();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 60, 60, 61, 61);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL nostb_sb[%0d]: got %b want %b", i, obs(), e); end
      checks++;
      if (hit !== 1'b0) begin failures++; $display("FAIL nostb_hit[%0d]: got %b want 0", i, hit); end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_respawn();
    test_boundary();
    test_respawn();
    test_grace();
    test_game_over();
    test_reset_mid();
    test_no_stb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
